adder_accumulator: RTL and testbench
====================================

// Module: adder_accumulator
//
// PURPOSE
// - Streaming accumulator that consumes the sum_o of the ripple-carry adder and feeds it back as the adder's a_i operand.
// - Sums exactly els_p unsigned samples received over a valid/ready input and presents one result on a valid/ready output.
// - Sits directly downstream of the adder in the arithmetic datapath and is the adder's only consumer in this stage.
//
// PARAMETERS
// - width_p   default 5  width of each input sample (unsigned)
// - els_p     default 4  samples per result; legal range >= 2
// - sum_width_lp  localparam = width_p + $clog2(els_p)  result width, cannot overflow
//
// PORTS
// - clk_i    in   1             clock; all state updates on rising edge
// - reset_i  in   1             asynchronous, active-high reset
// - valid_i  in   1             data_i is valid this cycle
// - data_i   in   width_p       sample to accumulate, unsigned
// - ready_o  out  1             block accepts data_i this cycle
// - valid_o  out  1             sum_o holds a completed result
// - sum_o    out  sum_width_lp  sum of the last els_p accepted samples
// - ready_i  in   1             downstream takes sum_o this cycle
//
// BEHAVIOUR
// - Reset (async assert, sync release): state=ACCUM, acc=0, count=0, ready_o=1, valid_o=0, sum_o=0.
// - Input handshake: a sample transfers when valid_i && ready_o on a rising edge. data_i is ignored otherwise.
// - Output handshake: a result transfers when valid_o && ready_i. Once valid_o is high, sum_o and valid_o stay stable until the transfer.
// - State ACCUM:
//   - ready_o=1, valid_o=0.
//   - On transfer with count < els_p-1: acc <= adder(acc, zext(data_i)) truncated to sum_width_lp; count <= count+1.
//   - On transfer with count == els_p-1: sum_o <= adder(acc, zext(data_i)); acc <= 0; count <= 0; go to DONE.
// - State DONE:
//   - ready_o=0, valid_o=1.
//   - On ready_i: go to ACCUM. sum_o keeps its last value; it is don't-care while valid_o=0.
// - Latency: valid_o rises the cycle after the clock edge that accepts the els_p-th sample. ready_o rises the cycle after the output transfer.
//   - Minimum spacing between results is therefore els_p+1 cycles. This one-cycle bubble is intentional.
// - Arithmetic:
//   - One adder instance at width sum_width_lp; a_i=acc, b_i=zero-extended data_i.
//   - The adder's MSB (the carry-out bit) is dropped; it is provably 0 because max sum = els_p*(2^width_p-1) < 2^sum_width_lp.
// - Boundaries:
//   - Gaps in valid_i: acc and count hold.
//   - ready_i high in ACCUM: ignored.
//   - valid_i high in DONE: no accept; the sample must be held by the source.
//   - count wraps only via the els_p-1 -> 0 transition; there is no other wrap path.
//   - reset_i mid-accumulation or mid-DONE: partial sum and pending result are discarded and the block returns to reset values immediately.
//
// STRUCTURE
// - Package adder_accum_pkg: typedef enum logic [0:0] {ACCUM, DONE} adder_accum_state_e.
// - Sub-module: one instance of the existing adder module with width_p = sum_width_lp. No other sub-modules.
// - Registers: state, acc[sum_width_lp], count[$clog2(els_p)], sum_o register.
//
// TESTING (width_p=5, els_p=4, sum_width_lp=7)
// - valid_i=1 with 1,2,3,4 on consecutive cycles, ready_i=1 -> sum_o=10, valid_o high exactly 1 cycle, ready_o=0 that cycle.
// - Four samples of 31 -> sum_o=124 with no overflow; next group 0,0,0,0 -> sum_o=0 (acc cleared).
// - Result 10 pending, ready_i=0 for 5 cycles while valid_i=1, data_i=7:
//   - valid_o=1, sum_o=10 held, ready_o=0, no sample accepted.
//   - After ready_i=1, the group 7,7,7,7 -> sum_o=28.
// - Samples 5,_,6,_,_,7,8 with valid_i gaps -> sum_o=26; no extra sample counted during gaps.
// - Accept 9,9, assert reset_i mid-cycle (async):
//   - Outputs go to reset values immediately.
//   - After release, 1,1,1,1 -> sum_o=4.
// - Random stream of 1000 samples with random valid_i/ready_i -> every result equals the scoreboard sum of 4 accepted samples, in order.

Source files
------------

// File: rtl/adder_accum_pkg.sv
// Shared types for the adder-fed streaming accumulator.
package adder_accum_pkg;

    // ACCUM: taking samples; DONE: holding a finished result for the consumer.
    typedef enum logic [0:0] {ACCUM, DONE} adder_accum_state_e;

endpackage

// File: rtl/adder.sv
// Ripple-carry adder: width_p-bit operands, (width_p+1)-bit sum with carry-out as MSB.
module adder #(
    parameter int width_p = 8
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p:0]   sum_o
);

    logic [width_p:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < width_p; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign sum_o[width_p] = carry[width_p];

endmodule

// File: rtl/adder_accumulator.sv
// Streaming accumulator: sums els_p unsigned samples through the ripple-carry
// adder and offers each total on a valid/ready output.
module adder_accumulator
    import adder_accum_pkg::*;
#(
    parameter  int width_p      = 5,
    parameter  int els_p        = 4,
    localparam int sum_width_lp = width_p + $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [sum_width_lp-1:0] sum_o,
    input  logic                    ready_i
);

    localparam int count_w_lp = $clog2(els_p);
    localparam logic [count_w_lp-1:0] last_count_lp = count_w_lp'(els_p - 1);

    adder_accum_state_e      state_r;
    logic [sum_width_lp-1:0] acc_r;
    logic [sum_width_lp-1:0] sum_r;
    logic [count_w_lp-1:0]   count_r;

    logic [sum_width_lp-1:0] data_ext;
    logic [sum_width_lp:0]   add_sum;
    logic [sum_width_lp-1:0] acc_next;
    logic                    carry_unused;
    logic                    accept;

    assign data_ext = sum_width_lp'(data_i);

    adder #(
        .width_p(sum_width_lp)
    ) u_adder (
        .a_i  (acc_r),
        .b_i  (data_ext),
        .sum_o(add_sum)
    );

    // The carry-out can never be set: els_p*(2^width_p-1) fits in sum_width_lp bits.
    assign acc_next     = add_sum[sum_width_lp-1:0];
    assign carry_unused = add_sum[sum_width_lp];

    assign ready_o = (state_r == ACCUM);
    assign valid_o = (state_r == DONE);
    assign sum_o   = sum_r;
    assign accept  = valid_i && (state_r == ACCUM);

    // Accumulate accepted samples; on the last one latch the total and hold it until taken.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ACCUM;
            acc_r   <= '0;
            count_r <= '0;
            sum_r   <= '0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept) begin
                        if (count_r == last_count_lp) begin
                            sum_r   <= acc_next;
                            acc_r   <= '0;
                            count_r <= '0;
                            state_r <= DONE;
                        end else begin
                            acc_r   <= acc_next;
                            count_r <= count_r + count_w_lp'(1);
                        end
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_r <= ACCUM;
                    end
                end
                default: state_r <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator (width_p=5, els_p=4): directed groups plus a
// randomized stream, all results checked by an in-order scoreboard.
module tb_adder_accumulator;

    localparam int W   = 5;
    localparam int N   = 4;
    localparam int SW  = 7;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b1;
    logic          valid_i = 1'b0;
    logic [W-1:0]  data_i  = '0;
    logic          ready_o;
    logic          valid_o;
    logic [SW-1:0] sum_o;
    logic          ready_i = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_results = 0;
    int n_expected = 0;

    logic [W-1:0]  samples[$];
    logic [SW-1:0] expq[$];

    logic          prev_hold = 1'b0;
    logic          prev_out  = 1'b0;
    logic          prev_last = 1'b0;
    logic [SW-1:0] prev_sum  = '0;

    adder_accumulator #(
        .width_p(W),
        .els_p  (N)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .data_i (data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .sum_o  (sum_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor at the falling edge: inputs and outputs seen here are what the next rising edge acts on.
    always @(negedge clk_i) begin
        if (reset_i) begin
            samples.delete();
            expq.delete();
            prev_hold = 1'b0;
            prev_out  = 1'b0;
            prev_last = 1'b0;
        end else begin
            logic last_now;
            int   s;
            last_now = 1'b0;
            if (prev_hold) begin
                check("hold_valid", int'(valid_o), 1);
                check("hold_sum", int'(sum_o), int'(prev_sum));
            end
            if (prev_out) begin
                check("bubble_valid", int'(valid_o), 0);
                check("bubble_ready", int'(ready_o), 1);
            end
            if (prev_last) begin
                check("latency_valid", int'(valid_o), 1);
                check("latency_ready", int'(ready_o), 0);
            end
            check("ready_vs_valid", int'(ready_o), int'(!valid_o));
            if (valid_o && ready_i) begin
                n_results++;
                if (expq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("result_sum", int'(sum_o), int'(expq.pop_front()));
                end
            end
            if (valid_i && ready_o) begin
                samples.push_back(data_i);
                if (samples.size() == N) begin
                    s = 0;
                    foreach (samples[i]) s += int'(samples[i]);
                    expq.push_back(SW'(s));
                    n_expected++;
                    samples.delete();
                    last_now = 1'b1;
                end
            end
            prev_hold = valid_o && !ready_i;
            prev_out  = valid_o && ready_i;
            prev_last = last_now;
            prev_sum  = sum_o;
        end
    end

    // Present one sample and keep it until the block accepts it.
    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   n;
        valid_i = 1'b1;
        data_i  = d;
        n = 0;
        forever begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        ready_i = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain_pending", expq.size(), 0);
    endtask

    logic rnd_done = 1'b0;

    initial begin
        #12;
        check("rst_ready", int'(ready_o), 1);
        check("rst_valid", int'(valid_o), 0);
        check("rst_sum", int'(sum_o), 0);
        @(negedge clk_i);
        #1 reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // 1,2,3,4 back to back -> 10
        for (int i = 1; i <= 4; i++) send(W'(i));
        idle(3);

        // Max-value group then a zero group
        for (int i = 0; i < 4; i++) send(W'(31));
        for (int i = 0; i < 4; i++) send(W'(0));
        idle(3);

        // Result 10 stalled for 5 cycles while a 7 is waiting
        ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) send(W'(i));
        valid_i = 1'b1;
        data_i  = W'(7);
        repeat (5) begin
            @(negedge clk_i);
            check("stall_valid", int'(valid_o), 1);
            check("stall_sum", int'(sum_o), 10);
            check("stall_ready", int'(ready_o), 0);
        end
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        for (int i = 0; i < 4; i++) send(W'(7));
        idle(3);

        // Gaps in valid_i: 5,_,6,_,_,7,8 -> 26
        send(W'(5)); idle(1);
        send(W'(6)); idle(2);
        send(W'(7));
        send(W'(8));
        idle(3);
        check("directed_results", n_results, 6);

        // Reset in the middle of a group
        send(W'(9));
        send(W'(9));
        #2 reset_i = 1'b1;
        #1;
        check("async_rst_ready", int'(ready_o), 1);
        check("async_rst_valid", int'(valid_o), 0);
        check("async_rst_sum", int'(sum_o), 0);
        @(negedge clk_i);
        #1 reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) send(W'(1));
        idle(3);

        // Randomized stream with random valid gaps and downstream stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(W'($urandom_range(0, 31)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i);
                    #1 ready_i = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        idle(2);
        check("result_count", n_results, n_expected);
        check("random_results_seen", (n_results >= 250) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
